// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, fetch FSM encoding and the
// fetch queue entry layout used by instr_fetch and fetch_fifo.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // ERR is only ever entered when FETCH_MISALIGN_CHECK_EN is defined.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] word;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue. The head lives in its own register so decode sees
// registered instr_word/instr_pc; a word pushed in cycle N is visible in N+1.
// Flush empties the queue and takes priority over push and pop.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t second;
    logic         do_push;
    logic         do_pop;

    // Qualify requests: never pop an empty queue, never overwrite a full one.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
    end

    // Shift-style storage: entry 1 moves into the head slot on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            second <= '0;
            count  <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               second <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= second;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head   <= second;
                        second <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory, queues returned words (2 entries) for decode, and
// handles redirects from execute including flush and killing an in-flight fetch.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready. The response channel has no ready:
// imem_rsp_valid is taken whenever it is high while a request is outstanding.
//
// Optional build macro FETCH_MISALIGN_CHECK_EN: adds fetch_misaligned and the
// ERR state; without it, redirect_pc[1:0] is ignored (forced to zero).
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,   // must equal riscv_pkg::XLEN
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_word,
    output logic [XLEN-1:0] instr_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            fetch_misaligned,
`endif
    output logic [1:0]      fsm_state
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n, target;
    logic            outstanding, out_n;
    logic            drop, drop_n;
    logic            req_fire, credit;
    logic            push, pop, flush;
    logic [1:0]      count;
    fetch_entry_t    head;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            misaligned_n;
    logic            bad_redirect;
`endif

    // Redirect target; low bits only matter to the misalignment checker.
    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        target       = redirect_pc;
        bad_redirect = (redirect_pc[1:0] != 2'b00);
`else
        target       = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif
    end

    // Next-state, PC, queue control; redirect overrides everything else.
    always_comb begin
        req_fire = (state == REQ) && imem_req_ready;
        credit   = (count + {1'b0, outstanding}) < 2'd2;
        state_n  = state;
        pc_n     = pc;
        out_n    = outstanding;
        drop_n   = drop;
        push     = 1'b0;
        pop      = instr_valid && instr_ready;
        flush    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misaligned_n = fetch_misaligned;
`endif
        case (state)
            IDLE: if (credit) state_n = REQ;
            REQ: begin
                if (req_fire) begin
                    out_n   = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    out_n = 1'b0;
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        push = 1'b1;
                        pc_n = pc + XLEN'(PC_STEP);
                        // Credit after this cycle's push and pop.
                        state_n = ((count == 2'd0) || ((count == 2'd1) && pop)) ? REQ : IDLE;
                    end
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            ERR: begin
                // Absorb a fetch still in flight from before the bad redirect.
                if (imem_rsp_valid && outstanding) begin
                    out_n  = 1'b0;
                    drop_n = 1'b0;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        if (redirect_valid) begin
            flush   = 1'b1;
            push    = 1'b0;
            pop     = 1'b0;
            pc_n    = target;
            // A response landing now is discarded; anything still in flight is dropped later.
            out_n   = req_fire || (outstanding && !imem_rsp_valid);
            drop_n  = out_n;
            state_n = out_n ? WAIT : REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_n = bad_redirect;
            if (bad_redirect) state_n = ERR;
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fetch_misaligned <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            outstanding <= out_n;
            drop        <= drop_n;
`ifdef FETCH_MISALIGN_CHECK_EN
            fetch_misaligned <= misaligned_n;
`endif
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  ('{word: imem_rsp_data, pc: pc}),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .head_valid (instr_valid),
        .count      (count)
    );

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign instr_word     = head.word;
    assign instr_pc       = head.pc;
    assign fsm_state      = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory responder with random ready/latency, a
// transaction-level reference model of the fetch stream (expected request
// address, expected queue of {word, pc}), directed scenarios and a random phase.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_word, instr_pc;
    logic [1:0]  fsm_state;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_word     (instr_word),
        .instr_pc       (instr_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents: the two words from the bring-up program, then a hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0050_0093;
        return {a[15:0], a[31:16]} ^ 32'h5A3C_9E71;
    endfunction

    // ---------------- memory responder ----------------
    int          ready_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          inject_stale = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_lat;

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (inject_stale) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
                inject_stale   = 1'b0;
            end else if (pend) begin
                if (pend_lat == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_lat--;
                end
            end
            imem_req_ready = ($urandom_range(99, 0) < ready_pct);
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                pend_lat  = $urandom_range(lat_max, lat_min);
            end
        end
    end

    // ---------------- reference model + compare ----------------
    logic [63:0] exp_q[$];          // {word, pc} decode must see, in order
    logic [31:0] exp_fetch = RESET_PC;
    bit          inflight = 1'b0;
    bit          killed = 1'b0;
    bit          err = 1'b0;
    logic [31:0] infl_addr;
    int          sz0;
    int          cyc = 0;
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [63:0] del_log[$];
    int          del_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                inflight  = 1'b0;
                killed    = 1'b0;
                err       = 1'b0;
                exp_fetch = RESET_PC;
                cyc       = 0;
            end else begin
                sz0 = exp_q.size();
                check("instr_valid", instr_valid, (sz0 > 0));
                if (sz0 > 0 && instr_valid) begin
                    check("instr_word", instr_word, exp_q[0][63:32]);
                    check("instr_pc", instr_pc, exp_q[0][31:0]);
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                check("fetch_misaligned", fetch_misaligned, err);
`endif
                if (imem_req_valid)
                    check("req_addr", imem_req_addr, exp_fetch);
                // pop (ignored under redirect)
                if (instr_valid && instr_ready && !redirect_valid && sz0 > 0) begin
                    del_log.push_back({instr_word, instr_pc});
                    del_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
                // response for the outstanding fetch
                if (imem_rsp_valid && inflight) begin
                    if (!killed && !redirect_valid) begin
                        check("push_room", (exp_q.size() < 2), 1);
                        exp_q.push_back({mem_word(infl_addr), infl_addr});
                        exp_fetch = infl_addr + 32'd4;
                    end
                    inflight = 1'b0;
                end
                // new request
                if (imem_req_valid && imem_req_ready) begin
                    check("req_credit", ((sz0 + int'(inflight)) < 2) && !err, 1);
                    req_log.push_back(imem_req_addr);
                    req_cyc.push_back(cyc);
                    inflight  = 1'b1;
                    killed    = 1'b0;
                    infl_addr = imem_req_addr;
                end
                // redirect: flush, kill, retarget
                if (redirect_valid) begin
                    exp_q.delete();
                    if (inflight) killed = 1'b1;
                    exp_fetch = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
                    err = (redirect_pc[1:0] != 2'b00);
`endif
                end
                cyc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_reqs(input int n, input int budget, input string name);
        int k = 0;
        while (req_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, (req_log.size() >= n), 1);
    endtask

    task automatic wait_dels(input int n, input int budget, input string name);
        int k = 0;
        while (del_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, (del_log.size() >= n), 1);
    endtask

    task automatic do_reset(input int lmin, input int lmax, input logic rdy);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        req_log.delete(); req_cyc.delete();
        del_log.delete(); del_cyc.delete();
        lat_min = lmin; lat_max = lmax; ready_pct = 100;
        instr_ready = rdy;
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int n, d0;

    initial begin
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_word", instr_word, 0);
        check("rst_instr_pc", instr_pc, 0);

        // Bring-up: ready memory, 1-cycle response, stale response right after release.
        instr_ready = 1'b1;
        inject_stale = 1'b1;
        rst_n = 1'b1;
        wait_dels(2, 40, "bringup_dels");
        wait_reqs(3, 40, "bringup_reqs");
        check("first_req_cycle", req_cyc[0], 1);
        check("first_req_addr", req_log[0], 32'h0);
        check("req1_addr", req_log[1], 32'h4);
        check("req2_addr", req_log[2], 32'h8);
        check("req_spacing", req_cyc[1] - req_cyc[0], 2);
        check("first_del_cycle", del_cyc[0], 3);
        check("del0", del_log[0], {32'h0000_0013, 32'h0});
        check("del1", del_log[1], {32'h0050_0093, 32'h4});

        // Async reset mid-operation clears outputs immediately.
        rst_n = 1'b0;
        #1;
        check("midrst_req_valid", imem_req_valid, 0);
        check("midrst_instr_valid", instr_valid, 0);
        check("midrst_instr_pc", instr_pc, 0);
        check("midrst_req_addr", imem_req_addr, RESET_PC);

        // Decode stalled: exactly two words buffered, then fetch stops.
        do_reset(0, 0, 1'b0);
        repeat (12) tick();
        check("stall_reqs", req_log.size(), 2);
        check("stall_head_valid", instr_valid, 1);
        check("stall_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        wait_dels(2, 20, "stall_dels");
        check("stall_del0_pc", del_log[0][31:0], 32'h0);
        check("stall_del1_pc", del_log[1][31:0], 32'h4);
        wait_reqs(3, 20, "stall_resume");
        check("stall_resume_addr", req_log[2], 32'h8);

        // Redirect while waiting on the 0x8 fetch.
        do_reset(3, 3, 1'b1);
        wait_reqs(3, 60, "wait8_reqs");
        check("wait8_addr", req_log[2], 32'h8);
        pulse_redirect(32'h100);
        n  = req_log.size();
        d0 = del_log.size();
        wait_reqs(n + 1, 30, "redir_req");
        check("redir_req_addr", req_log[n], 32'h100);
        wait_dels(d0 + 1, 30, "redir_del");
        check("redir_del", del_log[d0], {32'h5B3C_9E71, 32'h100});

        // Redirect coinciding with a response and a pop.
        do_reset(1, 1, 1'b0);
        wait_reqs(2, 30, "coinc_reqs");
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        instr_ready = 1'b1;
        @(negedge clk);
        check("coinc_setup_rsp", imem_rsp_valid, 1);
        check("coinc_setup_head", instr_valid, 1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("coinc_flushed", instr_valid, 0);
        check("coinc_no_pop", del_log.size(), 0);
        wait_reqs(3, 30, "coinc_req");
        check("coinc_req_addr", req_log[2], 32'h300);
        wait_dels(1, 30, "coinc_del");
        check("coinc_del_pc", del_log[0][31:0], 32'h300);

        // PC wrap.
        lat_min = 0; lat_max = 0;
        pulse_redirect(32'hFFFF_FFFC);
        n  = req_log.size();
        d0 = del_log.size();
        wait_reqs(n + 2, 30, "wrap_reqs");
        check("wrap_req0", req_log[n], 32'hFFFF_FFFC);
        check("wrap_req1", req_log[n + 1], 32'h0);
        wait_dels(d0 + 2, 30, "wrap_dels");
        check("wrap_del0_pc", del_log[d0][31:0], 32'hFFFF_FFFC);
        check("wrap_del1_pc", del_log[d0 + 1][31:0], 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect parks fetch until an aligned one arrives.
        pulse_redirect(32'h102);
        n = req_log.size();
        repeat (5) tick();
        check("err_no_reqs", req_log.size(), n);
        check("err_flag_set", fetch_misaligned, 1);
        pulse_redirect(32'h200);
        check("err_flag_clear", fetch_misaligned, 0);
        wait_reqs(n + 1, 30, "err_resume");
        check("err_resume_addr", req_log[n], 32'h200);
`endif

        // Random phase with a mid-run reset.
        ready_pct = 70; lat_min = 0; lat_max = 3;
        d0 = del_log.size();
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(99, 0) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(3, 0) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
            end else begin
                redirect_valid = 1'b0;
            end
            if (i == 1500) rst_n = 1'b0;
            if (i == 1503) rst_n = 1'b1;
            tick();
        end
        redirect_valid = 1'b0;
        check("random_progress", (del_log.size() - d0) > 50, 1);
        instr_ready = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog.
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
